// File: rtl/ram_sdp_clr.sv
// Simple dual-port RAM with byte enables and a DEPTH-cycle sweep clear; read latency 1, all requests ignored while busy.
// Define RAM_BYPASS_EN for write-first read-during-write collisions; the default build is read-first.
module ram_sdp_clr #(
  parameter int data_width  = 8,
  parameter int adder_width = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [data_width/8-1:0] be,
  input  logic [adder_width-1:0]  w_adder,
  input  logic [data_width-1:0]   w_data,
  input  logic                    re,
  input  logic [adder_width-1:0]  r_adder,
  input  logic                    clr,
  output logic [data_width-1:0]   r_data,
  output logic                    r_valid,
  output logic                    busy
);

  localparam int DEPTH = 2 ** adder_width;
  localparam int NB    = data_width / 8;
  localparam logic [adder_width-1:0] LAST = '1;

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [adder_width-1:0] r_cnt;
  logic [adder_width-1:0] w_cnt_nxt;
  logic [data_width-1:0]  r_mem [DEPTH];
  logic                   w_idle;
  logic                   w_wr;
  logic                   w_rd;
  logic [data_width-1:0]  w_old;
  logic [data_width-1:0]  w_rd_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (clr) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      S_CLEAR: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == LAST) w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy   = (r_state == S_CLEAR);
    w_idle = (r_state == S_IDLE);
    w_wr   = w_idle & we;
    w_rd   = w_idle & re;
  end

  assign w_old = r_mem[r_adder];

`ifdef RAM_BYPASS_EN
  // Write-first: enabled bytes of a colliding write replace the stored bytes.
  logic [data_width-1:0] w_merge;
  always_comb begin
    w_merge = w_old;
    for (int i = 0; i < NB; i++) begin
      if (w_wr && be[i] && (w_adder == r_adder)) w_merge[8*i +: 8] = w_data[8*i +: 8];
    end
  end
  assign w_rd_val = w_merge;
`else
  assign w_rd_val = w_old;
`endif

  // Memory has no reset; zeroing only happens through the sweep.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) r_mem[w_adder][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_rd;
      if (w_rd) r_data <= w_rd_val;
    end
  end

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Bench for ram_sdp_clr: default 8-bit instance driven against a behavioural model, plus a 16-bit instance for byte enables.
module tb_ram_sdp_clr;

  localparam int DEPTH = 8;
`ifdef RAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0, re = 1'b0, clr = 1'b0;
  logic [0:0]  be = 1'b0;
  logic [2:0]  w_adder = '0, r_adder = '0;
  logic [7:0]  w_data = '0;
  logic [7:0]  r_data;
  logic        r_valid, busy;

  logic        we16 = 1'b0, re16 = 1'b0, clr16 = 1'b0;
  logic [1:0]  be16 = '0;
  logic [2:0]  wa16 = '0, ra16 = '0;
  logic [15:0] wd16 = '0;
  logic [15:0] rd16;
  logic        rv16, busy16;

  logic [7:0]  m_mem [DEPTH];
  int          m_left = DEPTH;
  logic [7:0]  m_rdata = '0;
  logic        m_rvalid = 1'b0;
  int          n_checks = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  ram_sdp_clr dut (
    .clk(clk), .rst_n(rst_n), .we(we), .be(be), .w_adder(w_adder), .w_data(w_data),
    .re(re), .r_adder(r_adder), .clr(clr), .r_data(r_data), .r_valid(r_valid), .busy(busy)
  );

  ram_sdp_clr #(.data_width(16), .adder_width(3)) dut16 (
    .clk(clk), .rst_n(rst_n), .we(we16), .be(be16), .w_adder(wa16), .w_data(wd16),
    .re(re16), .r_adder(ra16), .clr(clr16), .r_data(rd16), .r_valid(rv16), .busy(busy16)
  );

  // Drive one cycle and advance the model: a busy memory counts down its remaining sweep.
  task automatic step(input logic i_we, input logic i_be, input logic [2:0] i_wa, input logic [7:0] i_wd,
                      input logic i_re, input logic [2:0] i_ra, input logic i_clr);
    logic [7:0] old_v, new_v;
    we = i_we; be = i_be; w_adder = i_wa; w_data = i_wd; re = i_re; r_adder = i_ra; clr = i_clr;
    @(posedge clk);
    if (m_left > 0) begin
      m_mem[DEPTH - m_left] = 8'h00;
      m_left--;
      m_rvalid = 1'b0;
    end else begin
      old_v = m_mem[i_ra];
      new_v = (i_we && i_be) ? i_wd : m_mem[i_wa];
      m_rvalid = i_re;
      if (i_re) m_rdata = (BYP && i_we && i_wa == i_ra) ? new_v : old_v;
      m_mem[i_wa] = new_v;
      if (i_clr) m_left = DEPTH;
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic test_reset();
    #22;
    n_checks++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b expected 1", busy); end
    n_checks++; if (r_valid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b expected 0", r_valid); end
    n_checks++; if (r_data !== 8'h00) begin n_err++; $display("FAIL reset_rdata: got %h expected 00", r_data); end
    rst_n = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      idle();
      n_checks++;
      if (busy !== (i < DEPTH)) begin n_err++; $display("FAIL sweep_busy[%0d]: got %b expected %b", i, busy, i < DEPTH); end
    end
    for (int a = 0; a < DEPTH; a++) begin
      step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'(a), 1'b0);
      n_checks++;
      if (r_valid !== 1'b1 || r_data !== 8'h00) begin
        n_err++; $display("FAIL post_reset_read[%0d]: got v=%b d=%h expected v=1 d=00", a, r_valid, r_data);
      end
    end
    idle();
    n_checks++; if (r_valid !== 1'b0) begin n_err++; $display("FAIL rvalid_pulse: got %b expected 0", r_valid); end
  endtask

  task automatic test_write_read();
    step(1'b1, 1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 1'b0);
    n_checks++; if (r_valid !== 1'b0) begin n_err++; $display("FAIL wr_no_valid: got %b expected 0", r_valid); end
    step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b0);
    n_checks++;
    if (r_valid !== 1'b1 || r_data !== 8'hA5) begin
      n_err++; $display("FAIL read_a5: got v=%b d=%h expected v=1 d=a5", r_valid, r_data);
    end
    idle();
    n_checks++;
    if (r_valid !== 1'b0 || r_data !== 8'hA5) begin
      n_err++; $display("FAIL read_hold: got v=%b d=%h expected v=0 d=a5", r_valid, r_data);
    end
    step(1'b1, 1'b0, 3'd3, 8'hFF, 1'b0, 3'd0, 1'b0);
    step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b0);
    n_checks++; if (r_data !== 8'hA5) begin n_err++; $display("FAIL be_zero: got %h expected a5", r_data); end
  endtask

  task automatic test_byte_enable();
    we16 = 1'b1; be16 = 2'b11; wa16 = 3'd5; wd16 = 16'h1234;
    @(posedge clk); #1;
    be16 = 2'b10; wd16 = 16'hABCD;
    @(posedge clk); #1;
    we16 = 1'b0; be16 = 2'b00; re16 = 1'b1; ra16 = 3'd5;
    @(posedge clk); #1;
    re16 = 1'b0;
    n_checks++;
    if (rv16 !== 1'b1 || rd16 !== 16'hAB34) begin
      n_err++; $display("FAIL be16_merge: got v=%b d=%h expected v=1 d=ab34", rv16, rd16);
    end
  endtask

  task automatic test_collision();
    logic [7:0] exp_v;
    exp_v = BYP ? 8'h3C : 8'h5A;
    step(1'b1, 1'b1, 3'd2, 8'h5A, 1'b0, 3'd0, 1'b0);
    step(1'b1, 1'b1, 3'd2, 8'h3C, 1'b1, 3'd2, 1'b0);
    n_checks++;
    if (r_valid !== 1'b1 || r_data !== exp_v) begin
      n_err++; $display("FAIL collision: got v=%b d=%h expected v=1 d=%h", r_valid, r_data, exp_v);
    end
    step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b0);
    n_checks++; if (r_data !== 8'h3C) begin n_err++; $display("FAIL after_collision: got %h expected 3c", r_data); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom), 1'($urandom), 3'($urandom),
           $urandom_range(0, 24) == 0);
      n_checks++;
      if (r_valid !== m_rvalid || r_data !== m_rdata || busy !== (m_left > 0)) begin
        n_err++; $display("FAIL random[%0d]: got v=%b d=%h b=%b expected v=%b d=%h b=%b",
                          i, r_valid, r_data, busy, m_rvalid, m_rdata, m_left > 0);
      end
    end
    for (int i = 0; i < DEPTH + 1 && m_left > 0; i++) idle();
  endtask

  task automatic fill();
    for (int a = 0; a < DEPTH; a++) step(1'b1, 1'b1, 3'(a), 8'($urandom) | 8'h01, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic test_clear();
    fill();
    step(1'b1, 1'b1, 3'd5, 8'h77, 1'b1, 3'd5, 1'b1);
    n_checks++;
    if (r_valid !== 1'b1 || r_data !== m_rdata || busy !== 1'b1) begin
      n_err++; $display("FAIL clr_with_rw: got v=%b d=%h b=%b expected v=1 d=%h b=1", r_valid, r_data, busy, m_rdata);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 1'b1, 3'($urandom), 8'hEE, 1'b1, 3'($urandom), 1'($urandom));
      n_checks++;
      if (r_valid !== 1'b0 || r_data !== m_rdata || busy !== (i < DEPTH)) begin
        n_err++; $display("FAIL clr_busy[%0d]: got v=%b d=%h b=%b expected v=0 d=%h b=%b",
                          i, r_valid, r_data, busy, m_rdata, i < DEPTH);
      end
    end
    for (int a = 0; a < DEPTH; a++) begin
      step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'(a), 1'b0);
      n_checks++;
      if (r_valid !== 1'b1 || r_data !== 8'h00) begin
        n_err++; $display("FAIL clr_read[%0d]: got v=%b d=%h expected v=1 d=00", a, r_valid, r_data);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    fill();
    step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 1'b1);
    for (int i = 0; i < 4; i++) idle();
    rst_n = 1'b0;
    m_left = DEPTH; m_rdata = 8'h00; m_rvalid = 1'b0;
    #3;
    n_checks++;
    if (busy !== 1'b1 || r_valid !== 1'b0 || r_data !== 8'h00) begin
      n_err++; $display("FAIL mid_reset: got b=%b v=%b d=%h expected b=1 v=0 d=00", busy, r_valid, r_data);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      idle();
      n_checks++;
      if (busy !== (i < DEPTH)) begin n_err++; $display("FAIL restart_busy[%0d]: got %b expected %b", i, busy, i < DEPTH); end
    end
    for (int a = 0; a < DEPTH; a++) begin
      step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'(a), 1'b0);
      n_checks++;
      if (r_valid !== 1'b1 || r_data !== 8'h00) begin
        n_err++; $display("FAIL restart_read[%0d]: got v=%b d=%h expected v=1 d=00", a, r_valid, r_data);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) m_mem[a] = 8'h00;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_collision();
    test_random();
    test_clear();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_sdp_clr.md
RAM_SDP_CLR -- requirements
Module: ram_sdp_clr

Interface
REQ-001 SHALL have parameter data_width, default 8, read/write data width in bits, a multiple of 8.
REQ-002 SHALL have parameter adder_width, default 3, address width; depth DEPTH = 2**adder_width.
REQ-003 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port we  input  1  write request.
REQ-006 SHALL have port be  input  data_width/8  byte enables for the write; bit i covers bits [8i+7:8i].
REQ-007 SHALL have port w_adder  input  adder_width  write address.
REQ-008 SHALL have port w_data  input  data_width  write data.
REQ-009 SHALL have port re  input  1  read request.
REQ-010 SHALL have port r_adder  input  adder_width  read address.
REQ-011 SHALL have port clr  input  1  single-cycle request to zero the whole memory.
REQ-012 SHALL have port r_data  output  data_width  registered read data.
REQ-013 SHALL have port r_valid  output  1  r_data was updated by the read accepted on the previous edge.
REQ-014 SHALL have port busy  output  1  a clear sweep is in progress, so requests are ignored.

Function
REQ-015 SHALL have a two-state FSM, IDLE and CLEAR, plus an adder_width-bit sweep counter.
REQ-016 CLEAR SHALL write all-zero to memory[counter] each cycle; the counter increments by 1 per cycle.
REQ-017 CLEAR SHALL go to IDLE on the edge that writes address DEPTH-1; the sweep lasts exactly DEPTH cycles.
REQ-018 IDLE SHALL go to CLEAR with counter = 0 when clr = 1 is sampled.
REQ-019 busy SHALL be 1 exactly while the state is CLEAR.
REQ-020 clr sampled while busy = 1 SHALL be ignored; the sweep does not restart.
REQ-021 While busy = 1, we and re SHALL be ignored: no memory write, r_valid = 0, r_data held.
REQ-022 In IDLE, a write with we = 1 SHALL update only the bytes whose be bit is 1; we = 1 with be = 0 changes nothing.
REQ-023 In IDLE, re = 1 SHALL load r_data with memory[r_adder] on the same edge and set r_valid = 1 for one cycle (latency 1).
REQ-024 When re = 0, r_data SHALL hold its last value and r_valid SHALL be 0.
REQ-025 For a same-cycle read and write to the same address, r_data SHALL follow REQ-041/REQ-042.
REQ-026 Reads and writes to different addresses in the same cycle SHALL be independent.
REQ-027 clr = 1 together with we/re in IDLE: clr SHALL take effect and the write and read in that same cycle SHALL still be performed.
REQ-028 Address arithmetic SHALL wrap modulo DEPTH; no out-of-range access exists.

Reset
REQ-029 rst_n = 0 SHALL immediately force state = CLEAR, counter = 0, busy = 1, r_valid = 0 and r_data = 0.
REQ-030 After rst_n rises, the sweep SHALL start on the first clock edge; busy SHALL fall after DEPTH edges.
REQ-031 Memory contents SHALL NOT be reset directly; zeroing happens only through the sweep.
REQ-032 Reset asserted mid-sweep or mid-read SHALL abort it; the sweep then restarts from address 0.

Configuration
REQ-040 Macro RAM_BYPASS_EN SHALL select the read-during-write collision behaviour.
REQ-041 With RAM_BYPASS_EN defined, a collision SHALL be write-first: enabled bytes come from w_data, the other bytes from the old memory contents.
REQ-042 Without RAM_BYPASS_EN, a collision SHALL be read-first: r_data is the old memory[r_adder].
REQ-043 Port list, latency and all other behaviour SHALL be identical in both builds.

Verification
REQ-050 Reset release, defaults: busy = 1 for 8 cycles, then 0; reading addresses 0..7 returns 0x00 each with r_valid pulsing.
REQ-051 Write 0xA5 to address 3 with be = 1, then re at address 3 -> r_data = 0xA5, r_valid = 1 exactly one cycle later.
REQ-052 data_width = 16: write 0x1234, then write 0xABCD with be = 2'b10 to the same address, then read -> 0xAB34.
REQ-053 Write 0x5A to address 2, then collide: write 0x3C and read address 2 in the same cycle -> r_data = 0x3C with RAM_BYPASS_EN, 0x5A without.
REQ-054 Pulse clr after filling memory; drive we/re during busy -> no writes and r_valid = 0; afterwards all locations read 0x00.
REQ-055 Assert rst_n = 0 at sweep count 4, release -> busy lasts a full 8 cycles and memory reads all zero.
